// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle around the unified memory arbiter: fetch stage, data stage,
// hazard-unit stalls, the shared memory port and the watchdog error flag.
interface unified_mem_arbiter_if;
  // Fetch stage
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  // Data (load/store) stage
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  // Hazard unit
  logic        stall_f;
  logic        stall_m;
  // Shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // Sticky watchdog error
  logic        err;

  // The arbiter: serves both stages and masters the memory port.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, stall_f, stall_m,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );

  // The surroundings: pipeline stages plus the memory itself.
  modport slave (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_f, stall_m,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and load/store. One outstanding transaction, round-robin on ties, and a
// WAIT-state watchdog that aborts a transaction the memory never answers.
module unified_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255  // WAIT cycles before abort; 0 disables
) (
  input  logic                  clk,
  input  logic                  clr,    // asynchronous, active low
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic       {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_e;

  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam bit            WD_EN   = (TIMEOUT != 0);

  state_e        r_state;
  owner_e        r_owner;
  owner_e        r_last_owner;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_if_valid;
  logic          r_d_valid;
  logic          r_err;
  logic [CW-1:0] r_wd_cnt;

  logic          w_pick_data;
  logic          w_timeout;

  // Pick the next owner: on a tie the stage that did not go last wins.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would infer a latch.
    w_pick_data = 1'b0;
    if (bus.d_req && bus.if_req) begin
      w_pick_data = (r_last_owner == OWN_FETCH);
    end else begin
      w_pick_data = bus.d_req;
    end
  end

  assign w_timeout = WD_EN && (r_wd_cnt == WD_LAST);

  // Transaction FSM with registered memory fields, read data and valid pulses.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_FETCH;
      r_last_owner <= OWN_FETCH;
      r_we         <= 1'b0;
      r_be         <= 4'h0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_err        <= 1'b0;
      r_wd_cnt     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.if_req || bus.d_req) begin
            if (w_pick_data) begin
              r_owner <= OWN_DATA;
              r_we    <= bus.d_we;
              r_be    <= bus.d_be;
              r_addr  <= bus.d_addr;
              r_wdata <= bus.d_wdata;
            end else begin
              r_owner <= OWN_FETCH;
              r_we    <= 1'b0;
              r_be    <= 4'hF;
              r_addr  <= bus.if_addr;
              r_wdata <= '0;
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_gnt) begin
            r_state      <= S_WAIT;
            r_wd_cnt     <= '0;
            r_last_owner <= r_owner;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            if (r_owner == OWN_DATA) begin
              r_d_rdata <= bus.mem_rdata;
              r_d_valid <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_valid <= 1'b1;
            end
            r_state <= S_RESP;
          end else if (w_timeout) begin
            // Abort: complete the owner with zero data and flag the error.
            r_err <= 1'b1;
            if (r_owner == OWN_DATA) begin
              r_d_rdata <= '0;
              r_d_valid <= 1'b1;
            end else begin
              r_if_rdata <= '0;
              r_if_valid <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
        S_RESP: begin
          // Valid is high this cycle; no arbitration so the owner's held
          // request is not granted a second time.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (r_state == S_ISSUE);
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.err       = r_err;
  assign bus.stall_f   = bus.if_req & ~r_if_valid;
  assign bus.stall_m   = bus.d_req & ~r_d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a behavioural memory with
// configurable grant/response delay, a scoreboard of expected transactions
// checked at issue and completion, a vector table of single transactions and
// hand-written sequences for arbitration, backpressure, watchdog and reset.
module tb_unified_mem_arbiter;

  localparam int unsigned TB_TIMEOUT = 8;

  logic clk = 1'b0;
  logic clr;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected transaction as seen on the memory port and at completion.
  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  // One table vector: requester inputs, memory timing, expected outputs.
  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rsp_lat;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  txn_t exp_q[$];

  // ---------------- memory model ----------------
  int          cfg_gnt_dly = 0;
  int          cfg_rsp_lat = 1;
  bit          cfg_rsp_en  = 1'b1;
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_addr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(negedge clk) begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    if (!clr) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (bus.mem_req) begin
        if (m_cnt == cfg_gnt_dly) begin
          bus.mem_gnt = 1'b1;
          m_addr      = bus.mem_addr;
          m_phase     = cfg_rsp_en ? 1 : 0;
          m_cnt       = cfg_rsp_en ? 1 : 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (m_cnt == cfg_rsp_lat) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(m_addr);
        m_phase        = 0;
        m_cnt          = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit          mon_prev_req = 1'b0;
  bit          mon_prev_ifv = 1'b0;
  bit          mon_prev_dv  = 1'b0;
  logic [31:0] mon_if_rdata = '0;
  logic [31:0] mon_d_rdata  = '0;

  always @(negedge clk) begin
    txn_t t;
    if (!clr) begin
      mon_prev_req = 1'b0;
      mon_prev_ifv = 1'b0;
      mon_prev_dv  = 1'b0;
      mon_if_rdata = '0;
      mon_d_rdata  = '0;
    end else begin
      if (bus.mem_req && !mon_prev_req) begin
        check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("issue_addr",  bus.mem_addr,       exp_q[0].addr);
          check("issue_we",    32'(bus.mem_we),    32'(exp_q[0].we));
          check("issue_be",    32'(bus.mem_be),    32'(exp_q[0].be));
          check("issue_wdata", bus.mem_wdata,      exp_q[0].wdata);
        end
      end
      if (bus.if_valid || bus.d_valid) begin
        check("one_valid",   32'(bus.if_valid & bus.d_valid), 32'd0);
        check("valid_pulse", 32'((bus.if_valid & mon_prev_ifv) | (bus.d_valid & mon_prev_dv)), 32'd0);
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check("owner", 32'(bus.d_valid), 32'(t.is_data));
          if (t.is_data) begin
            check("d_rdata", bus.d_rdata, t.rdata);
            check("if_rdata_kept", bus.if_rdata, mon_if_rdata);
            mon_d_rdata = t.rdata;
          end else begin
            check("if_rdata", bus.if_rdata, t.rdata);
            check("d_rdata_kept", bus.d_rdata, mon_d_rdata);
            mon_if_rdata = t.rdata;
          end
        end
      end
      mon_prev_req = bus.mem_req;
      mon_prev_ifv = bus.if_valid;
      mon_prev_dv  = bus.d_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic txn_t mk_txn(input logic is_data, input logic we, input logic [3:0] be,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
    txn_t t;
    t.is_data = is_data; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Runs one transaction from an IDLE-aligned negedge; leaves one idle cycle.
  task automatic run_vec(input vec_t v, input bit rsp_en, input string tag);
    int cyc;
    bit done;
    logic stall;
    cfg_gnt_dly = v.gnt_dly;
    cfg_rsp_lat = v.rsp_lat;
    cfg_rsp_en  = rsp_en;
    exp_q.push_back(mk_txn(v.is_data, v.exp_we, v.exp_be, v.addr, v.exp_wdata, v.exp_rdata));
    if (v.is_data) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_be = v.be;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      stall = v.is_data ? bus.stall_m : bus.stall_f;
      if (v.is_data ? bus.d_valid : bus.if_valid) begin
        done = 1'b1;
        check({tag, "_latency"}, cyc, v.exp_lat);
        check({tag, "_stall_at_valid"}, 32'(stall), 32'd0);
      end else begin
        check({tag, "_stall_pending"}, 32'(stall), 32'd1);
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
  endtask

  // Waits for n completion pulses within a cycle budget.
  task automatic wait_valids(input int n, input int budget, input string tag);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.if_valid || bus.d_valid) seen++;
    end
    check({tag, "_completions"}, seen, n);
  endtask

  vec_t vecs[6];
  vec_t wd_vec;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         0, 2, 1'b0, 4'hF, 32'h0,         32'h0050_0093, 4};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0,         1, 1, 1'b0, 4'hF, 32'h0,         32'hC0DE_0300, 4};
    vecs[2] = '{1'b1, 1'b1, 4'hC, 32'h0000_0202, 32'hABCD_0000, 0, 3, 1'b1, 4'hC, 32'hABCD_0000, 32'hC0DE_0202, 5};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_01FC, 32'h0,         2, 8, 1'b0, 4'hF, 32'h0,         32'hC0DE_01FC, 12};
    vecs[4] = '{1'b1, 1'b0, 4'h3, 32'h0000_0000, 32'h0,         0, 1, 1'b0, 4'h3, 32'h0,         32'hC0DE_0000, 3};
    vecs[5] = '{1'b1, 1'b1, 4'h1, 32'h0000_0040, 32'h1234_5678, 0, 2, 1'b1, 4'h1, 32'h1234_5678, 32'hC0DE_0040, 4};
    wd_vec  = '{1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0,         0, 1, 1'b0, 4'hF, 32'h0,         32'h0,         10};

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    clr = 1'b0;
    #1;
    check("rst_mem_req",   32'(bus.mem_req),  32'd0);
    check("rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("rst_mem_be",    32'(bus.mem_be),   32'd0);
    check("rst_mem_addr",  bus.mem_addr,      32'd0);
    check("rst_mem_wdata", bus.mem_wdata,     32'd0);
    check("rst_if_valid",  32'(bus.if_valid), 32'd0);
    check("rst_d_valid",   32'(bus.d_valid),  32'd0);
    check("rst_if_rdata",  bus.if_rdata,      32'd0);
    check("rst_d_rdata",   bus.d_rdata,       32'd0);
    check("rst_err",       32'(bus.err),      32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Arbitration: both held continuously, data wins the first tie.
    cfg_gnt_dly = 0; cfg_rsp_lat = 1; cfg_rsp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk_txn(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'hC0DE_0200));
      exp_q.push_back(mk_txn(1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 32'hC0DE_0104));
    end
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h200; bus.d_wdata = 32'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    wait_valids(4, 60, "arb");
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    check("arb_queue_drained", exp_q.size(), 0);

    // Table of single transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Grant backpressure with requester inputs changed after latching
    cfg_gnt_dly = 5; cfg_rsp_lat = 1; cfg_rsp_en = 1'b1;
    exp_q.push_back(mk_txn(1'b1, 1'b0, 4'hF, 32'h500, 32'h1111_1111, 32'hC0DE_0500));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h500; bus.d_wdata = 32'h1111_1111;
    @(negedge clk);
    bus.d_we = 1'b1; bus.d_be = 4'h3; bus.d_addr = 32'h600; bus.d_wdata = 32'h2222_2222;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("bp_req_c%0d", c),   32'(bus.mem_req), 32'd1);
      check($sformatf("bp_addr_c%0d", c),  bus.mem_addr,     32'h500);
      check($sformatf("bp_we_c%0d", c),    32'(bus.mem_we),  32'd0);
      check($sformatf("bp_be_c%0d", c),    32'(bus.mem_be),  32'hF);
      check($sformatf("bp_wdata_c%0d", c), bus.mem_wdata,    32'h1111_1111);
      @(negedge clk);
    end
    check("bp_wait_req_low", 32'(bus.mem_req), 32'd0);
    wait_valids(1, 10, "bp");
    bus.d_req = 1'b0;
    @(negedge clk);

    // Watchdog: memory never answers
    check("wd_err_before", 32'(bus.err), 32'd0);
    run_vec(wd_vec, 1'b0, "wd");
    check("wd_err_set", 32'(bus.err), 32'd1);
    run_vec(vecs[4], 1'b1, "wd_after");
    check("wd_err_sticky", 32'(bus.err), 32'd1);

    // Reset while in ISSUE: mem_req must drop at once
    cfg_gnt_dly = 20; cfg_rsp_lat = 1; cfg_rsp_en = 1'b1;
    exp_q.push_back(mk_txn(1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 32'h0));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h700; bus.d_wdata = 32'h0;
    @(negedge clk);
    check("rst_issue_req_before", 32'(bus.mem_req), 32'd1);
    clr = 1'b0;
    #1;
    check("rst_issue_req_after", 32'(bus.mem_req), 32'd0);
    exp_q.delete();
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Reset while in WAIT
    cfg_gnt_dly = 0; cfg_rsp_lat = 6; cfg_rsp_en = 1'b1;
    exp_q.push_back(mk_txn(1'b1, 1'b0, 4'hF, 32'h704, 32'h0, 32'h0));
    bus.d_req = 1'b1; bus.d_addr = 32'h704;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_wait_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_wait_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_wait_d_valid",  32'(bus.d_valid),  32'd0);
    check("rst_wait_err",      32'(bus.err),      32'd0);
    exp_q.delete();
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle_c%0d", c), 32'(bus.mem_req), 32'd0);
    end

    // First tie after reset goes to data again
    cfg_gnt_dly = 0; cfg_rsp_lat = 1; cfg_rsp_en = 1'b1;
    exp_q.push_back(mk_txn(1'b1, 1'b0, 4'hF, 32'h208, 32'h0, 32'hC0DE_0208));
    exp_q.push_back(mk_txn(1'b0, 1'b0, 4'hF, 32'h10C, 32'h0, 32'hC0DE_010C));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h208; bus.d_wdata = 32'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10C;
    wait_valids(1, 20, "post_rst_first");
    bus.d_req = 1'b0;
    wait_valids(1, 20, "post_rst_second");
    bus.if_req = 1'b0;
    @(negedge clk);
    check("post_rst_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
